// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width default, pointer-width helper and stream beat type
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 32;

    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    typedef struct packed {
        logic [FIFO_WIDTH_DEF-1:0] data;
        logic                      last;
    } beat_t;

endpackage

// File: rtl/fifo_rd_streamer_if.sv
// fifo_rd_streamer_if: FIFO read port plus valid/ready output stream
interface fifo_rd_streamer_if
    import fifo_pkg::*;
#(
    parameter int W = FIFO_WIDTH_DEF
);
    logic         read_en;
    logic         fifo_empty;
    logic [W-1:0] read_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    modport master (
        output read_en, out_valid, out_data, out_last,
        input  fifo_empty, read_data, out_ready
    );

    modport slave (
        input  read_en, out_valid, out_data, out_last,
        output fifo_empty, read_data, out_ready
    );
endinterface

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: circular DEPTH-entry buffer catching words returning from the FIFO
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = FIFO_WIDTH_DEF,
    parameter int OW    = clog2_min1(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd,
    output logic [W-1:0]  rd_data,
    output logic [OW-1:0] occ
);
    localparam int PW = clog2_min1(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // storage is not reset; occ alone decides which entries are meaningful
    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= wr_data;

    // pointers wrap explicitly so non-power-of-2 depths work; wr and rd together leave occ unchanged
    always_ff @(posedge clk)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr) wr_ptr <= bump(wr_ptr);
            if (rd) rd_ptr <= bump(rd_ptr);
            occ <= occ + OW'(wr) - OW'(rd);
        end

    assign rd_data = mem[rd_ptr];

    assert property (@(posedge clk) disable iff (rst) !(wr && !rd && occ == OW'(DEPTH)));
    assert property (@(posedge clk) disable iff (rst) !(rd && occ == '0));
endmodule

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: drains the FIFO read port into a framed valid/ready stream
module fifo_rd_streamer
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int RD_LAT     = 1,
    parameter int FRAME_LEN  = 16,
    parameter int CNT_W      = 16
) (
    input  logic               rdclk,
    input  logic               rst_rdclk,
    input  logic               enable,
    fifo_rd_streamer_if.master bus,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic               busy
);
    localparam int DEPTH = RD_LAT + 1;
    localparam int OW    = clog2_min1(DEPTH + 1);

    logic [RD_LAT-1:0] sr;
    logic [OW-1:0]     occ, infl;
    logic              land, xfer;

    assign land = sr[RD_LAT-1];
    assign xfer = bus.out_valid & bus.out_ready;

    // pop only when every in-flight word is guaranteed a free slot on return
    assign bus.read_en = ~rst_rdclk & enable & ~bus.fifo_empty &
                         (int'(occ) + int'(infl) - int'(xfer) < DEPTH);

    // read_en travels down this pipe; its tail marks read_data valid
    always_ff @(posedge rdclk)
        sr <= rst_rdclk ? '0 : RD_LAT'({sr, bus.read_en});

    // pops in flight = ones in the latency pipe
    always_comb begin
        infl = '0;
        for (int i = 0; i < RD_LAT; i++) infl = infl + OW'(sr[i]);
    end

    fifo_skid_buf #(.DEPTH(DEPTH), .W(FIFO_WIDTH), .OW(OW)) u_skid (
        .clk     (rdclk),
        .rst     (rst_rdclk),
        .wr      (land),
        .wr_data (bus.read_data),
        .rd      (xfer),
        .rd_data (bus.out_data),
        .occ     (occ)
    );

    assign bus.out_valid = |occ;
    assign bus.out_last  = bus.out_valid & (frame_cnt == CNT_W'(FRAME_LEN - 1));
    assign busy          = (|occ) | (|sr);

    // frame position advances per transfer and wraps on the last word; held otherwise
    always_ff @(posedge rdclk)
        if (rst_rdclk) frame_cnt <= '0;
        else if (xfer) frame_cnt <= bus.out_last ? '0 : frame_cnt + 1'b1;
endmodule
